// File: rtl/issue_ctrl.sv
// Scoreboard issue controller: holds one decoded instruction, tracks pending
// register writes, issues to EX when operands are free. Optional SCOREBOARD_BYPASS_EN.
module issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int OPT_SIZE   = 7,
  parameter int FUNCT_SIZE = 3,
  parameter int REG_SIZE   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OPT_SIZE-1:0]   id_opt,
  input  logic [FUNCT_SIZE-1:0] id_funct,
  input  logic [REG_SIZE-1:0]   id_rs1,
  input  logic [REG_SIZE-1:0]   id_rs2,
  input  logic [REG_SIZE-1:0]   id_rd,
  input  logic [DATA_WIDTH-1:0] id_imm,
  output logic                  id_vacant,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [OPT_SIZE-1:0]   ex_opt,
  output logic [FUNCT_SIZE-1:0] ex_funct,
  output logic [REG_SIZE-1:0]   ex_rs1,
  output logic [REG_SIZE-1:0]   ex_rs2,
  output logic [REG_SIZE-1:0]   ex_rd,
  output logic [DATA_WIDTH-1:0] ex_imm,
  input  logic                  wb_valid,
  input  logic [REG_SIZE-1:0]   wb_rd,
  input  logic                  br_done,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);
  localparam int NREGS = 2**REG_SIZE;
  localparam logic [OPT_SIZE-1:0] OP_B = OPT_SIZE'(7'b1100011);
  localparam logic [OPT_SIZE-1:0] OP_L = OPT_SIZE'(7'b0000011);
  localparam logic [OPT_SIZE-1:0] OP_S = OPT_SIZE'(7'b0100011);
  localparam logic [OPT_SIZE-1:0] OP_I = OPT_SIZE'(7'b0010011);
  localparam logic [OPT_SIZE-1:0] OP_R = OPT_SIZE'(7'b0110011);
  localparam logic [NREGS-1:0]    ONE  = {{(NREGS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {EMPTY, HOLD, WAIT_BR} state_t;

  state_t           state;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_eff, wb_mask, set_mask;
  logic [3:0]       ex_dec, id_dec;
  logic             hazard, issue, is_br, accept, id_legal;

  // {legal, uses rs1, uses rs2, uses rd}
  function automatic logic [3:0] decode(input logic [OPT_SIZE-1:0] op);
    case (op)
      OP_B:    decode = 4'b1110;
      OP_L:    decode = 4'b1101;
      OP_S:    decode = 4'b1110;
      OP_I:    decode = 4'b1101;
      OP_R:    decode = 4'b1111;
      default: decode = 4'b0000;
    endcase
  endfunction

  assign ex_dec   = decode(ex_opt);
  assign id_dec   = decode(id_opt);
  assign id_legal = id_dec[3];
  assign wb_mask  = (wb_valid && wb_rd != '0) ? (ONE << wb_rd) : '0;

`ifdef SCOREBOARD_BYPASS_EN
  assign busy_eff = busy & ~wb_mask;
`else
  assign busy_eff = busy;
`endif

  // busy[0] is never set, so x0 operands can never stall
  assign hazard    = (ex_dec[2] && busy_eff[ex_rs1]) ||
                     (ex_dec[1] && busy_eff[ex_rs2]) ||
                     (ex_dec[0] && busy_eff[ex_rd]);
  assign ex_valid  = (state == HOLD) && !hazard;
  assign issue     = ex_valid && ex_ready;
  assign is_br     = (ex_opt == OP_B);
  assign id_vacant = (state == EMPTY) || ((state == HOLD) && issue && !is_br);
  assign accept    = id_valid && id_vacant;
  assign set_mask  = (issue && ex_dec[0] && ex_rd != '0) ? (ONE << ex_rd) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      busy      <= '0;
      illegal   <= 1'b0;
      stall_cnt <= '0;
      ex_opt    <= '0;
      ex_funct  <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_imm    <= '0;
    end else begin
      // set after clear: an issue beats a same-cycle writeback of that register
      busy    <= (busy & ~wb_mask) | set_mask;
      illegal <= accept && !id_legal;
      if (state == HOLD && (hazard || !ex_ready) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;

      if (accept && id_legal) begin
        ex_opt   <= id_opt;
        ex_funct <= id_funct;
        ex_rs1   <= id_rs1;
        ex_rs2   <= id_rs2;
        ex_rd    <= id_rd;
        ex_imm   <= id_imm;
      end

      case (state)
        EMPTY:   if (accept && id_legal) state <= HOLD;
        HOLD:    if (issue) begin
                   if (is_br)                    state <= WAIT_BR;
                   else if (accept && id_legal)  state <= HOLD;
                   else                          state <= EMPTY;
                 end
        WAIT_BR: if (br_done) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized + directed bench for issue_ctrl: a queue-based scoreboard of
// accepted instructions and a per-cycle behavioural model of issue/stall rules.
module tb_issue_ctrl;
  localparam logic [6:0] OP_B = 7'b1100011, OP_L = 7'b0000011, OP_S = 7'b0100011,
                         OP_I = 7'b0010011, OP_R = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opt;
    logic [2:0]  funct;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
  } instr_t;

  logic        clk = 0, rst_n = 0;
  logic        id_valid = 0, ex_ready = 0, wb_valid = 0, br_done = 0;
  logic [6:0]  id_opt = 0;
  logic [2:0]  id_funct = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0, wb_rd = 0;
  logic [31:0] id_imm = 0;
  logic        id_vacant, ex_valid, illegal;
  logic [6:0]  ex_opt;
  logic [2:0]  ex_funct;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_imm;
  logic [15:0] stall_cnt;

  issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opt(id_opt), .id_funct(id_funct),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_vacant(id_vacant),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opt(ex_opt), .ex_funct(ex_funct),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .br_done(br_done), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  instr_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {legal, uses rs1, uses rs2, uses rd} straight from the opcode table
  function automatic logic [3:0] fields(input logic [6:0] op);
    if (op == OP_B || op == OP_S) return 4'b1110;
    if (op == OP_L || op == OP_I) return 4'b1101;
    if (op == OP_R)               return 4'b1111;
    return 4'b0000;
  endfunction

  // reference model state
  logic        m_held, m_wait, m_ill;
  instr_t      m_instr;
  logic [31:0] m_busy, m_eff;
  logic [15:0] m_stall;
  logic        m_hz, m_ev, m_iss, m_vac, m_acc;
  logic [3:0]  m_f, c_f;
  instr_t      cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_held = 0; m_wait = 0; m_ill = 0; m_busy = 0; m_stall = 0;
      exp_q.delete();
    end else begin
      cur   = '{id_opt, id_funct, id_rs1, id_rs2, id_rd, id_imm};
      m_eff = m_busy;
`ifdef SCOREBOARD_BYPASS_EN
      if (wb_valid) m_eff[wb_rd] = 1'b0;
`endif
      m_f  = fields(m_instr.opt);
      m_hz = m_held && ((m_f[2] && m_eff[m_instr.rs1]) || (m_f[1] && m_eff[m_instr.rs2]) ||
                        (m_f[0] && m_eff[m_instr.rd]));
      m_ev  = m_held && !m_hz;
      m_iss = m_ev && ex_ready;
      m_vac = !m_wait && (!m_held || (m_iss && m_instr.opt != OP_B));
      m_acc = id_valid && m_vac;
      chk("ex_valid", 64'(ex_valid), 64'(m_ev));
      chk("id_vacant", 64'(id_vacant), 64'(m_vac));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("illegal", 64'(illegal), 64'(m_ill));
      if (m_held && (m_hz || !ex_ready) && m_stall != 16'hffff) m_stall++;
      if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 1'b0;
      if (m_iss) begin
        if (m_f[0] && m_instr.rd != 0) m_busy[m_instr.rd] = 1'b1;
        if (m_instr.opt == OP_B) m_wait = 1;
        m_held = 0;
      end else if (m_wait && br_done) m_wait = 0;
      c_f   = fields(id_opt);
      m_ill = m_acc && !c_f[3];
      if (m_acc && c_f[3]) begin
        m_held = 1; m_instr = cur; exp_q.push_back(cur);
      end
    end
  end

  // monitor: every issue must be the oldest accepted instruction, unchanged
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) chk("issue_unexpected", 64'(ex_opt), 64'hdead);
      else chk("issue_instr", 64'({ex_opt, ex_funct, ex_rs1, ex_rs2, ex_rd, ex_imm}),
               64'(exp_q.pop_front()));
    end
  end

  function automatic instr_t mk(input logic [6:0] op, input logic [4:0] r1, r2, rd);
    instr_t i;
    i = '{op, 3'($urandom), r1, r2, rd, $urandom};
    return i;
  endfunction

  task automatic drive(input logic v, input instr_t i, input logic rdy,
                       input logic wbv, input logic [4:0] wbr, input logic brd);
    id_valid = v; id_opt = i.opt; id_funct = i.funct; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_rd = i.rd; id_imm = i.imm; ex_ready = rdy; wb_valid = wbv; wb_rd = wbr; br_done = brd;
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  instr_t idle, ib;
  logic [6:0] ops [0:6];
  logic bypass;

  initial begin
`ifdef SCOREBOARD_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
    ops = '{OP_B, OP_L, OP_S, OP_I, OP_R, 7'h7f, 7'h00};
    idle = '0;
    drive(0, idle, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_vacant", 64'(id_vacant), 1); chk("rst_ex_valid", 64'(ex_valid), 0);
    chk("rst_stall", 64'(stall_cnt), 0);
    nxt();

    // back-to-back independent ops
    drive(1, mk(OP_I, 0, 0, 1), 1, 0, 0, 0); nxt();
    drive(1, mk(OP_R, 2, 4, 3), 1, 0, 0, 0);
    @(negedge clk); chk("b2b_first", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd1})); nxt();
    drive(0, idle, 1, 0, 0, 0);
    @(negedge clk); chk("b2b_second", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd3})); nxt();
    @(negedge clk); chk("b2b_busy", 64'(dut.busy[3:0]), 64'(4'b1010)); nxt();
    drive(0, idle, 1, 1, 1, 0); nxt();
    drive(0, idle, 1, 1, 3, 0); nxt();

    // RAW stall on x5
    drive(1, mk(OP_I, 0, 0, 5), 1, 0, 0, 0); nxt();
    drive(1, mk(OP_R, 5, 0, 6), 1, 0, 0, 0); nxt();
    drive(0, idle, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("raw_stalled", 64'(ex_valid), 0); nxt();
    end
    drive(0, idle, 1, 1, 5, 0);
    @(negedge clk); chk("raw_stall_cnt", 64'(stall_cnt), 4);
    chk("raw_wb_issue", 64'(ex_valid), 64'(bypass)); nxt();
    drive(0, idle, 1, 0, 0, 0);
    @(negedge clk); chk("raw_next_issue", 64'(ex_valid), 64'(!bypass)); nxt();
    drive(0, idle, 1, 1, 6, 0); nxt();

    // branch: decode blocked until br_done in cycle 7, accepted in cycle 8
    drive(1, mk(OP_B, 0, 0, 0), 1, 0, 0, 0);
    @(negedge clk); chk("br_accept", 64'(id_vacant), 1); nxt();
    ib = mk(OP_I, 0, 0, 2);
    drive(1, ib, 1, 0, 0, 0);
    @(negedge clk); chk("br_issue", 64'({ex_valid, id_vacant}), 64'(2'b10)); nxt();
    for (int k = 2; k <= 7; k++) begin
      drive(1, ib, 1, 0, 0, k == 7);
      @(negedge clk); chk("br_blocked", 64'(id_vacant), 0); nxt();
    end
    drive(1, ib, 1, 0, 0, 0);
    @(negedge clk); chk("br_reaccept", 64'(id_vacant), 1); nxt();
    drive(0, idle, 1, 0, 0, 0);
    @(negedge clk); chk("br_after", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd2})); nxt();
    drive(0, idle, 1, 1, 2, 0); nxt();

    // illegal opcode and rd=x0
    drive(1, mk(7'h7f, 0, 0, 0), 1, 0, 0, 0); nxt();
    drive(0, idle, 1, 0, 0, 0);
    @(negedge clk); chk("ill_pulse", 64'({illegal, ex_valid}), 64'(2'b10)); nxt();
    @(negedge clk); chk("ill_end", 64'(illegal), 0); nxt();
    drive(1, mk(OP_I, 3, 0, 0), 1, 0, 0, 0); nxt();
    drive(0, idle, 1, 0, 0, 0); nxt();
    @(negedge clk); chk("x0_busy", 64'(dut.busy), 0); nxt();

    // async reset while holding a stalled instruction
    drive(1, mk(OP_I, 0, 0, 7), 1, 0, 0, 0); nxt();
    drive(1, mk(OP_R, 7, 0, 8), 1, 0, 0, 0); nxt();
    drive(0, idle, 1, 0, 0, 0);
    @(negedge clk); chk("ar_pre", 64'({ex_valid, dut.busy[7]}), 64'(2'b01));
    #2 rst_n = 0;
    #1 chk("ar_ex_valid", 64'(ex_valid), 0); chk("ar_busy", 64'(dut.busy), 0);
    @(posedge clk); @(negedge clk); @(posedge clk); #1 rst_n = 1;

    // randomized traffic on a small register window
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0);
      nxt();
    end
    drive(0, idle, 1, 0, 0, 0);
    repeat (4) nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
